// File: rtl/ppc_pkg.sv
// rtl/ppc_pkg.sv - KPG encoding types and helpers for the pipelined prefix adder
// Purpose: shared carry-status encoding, the prefix combine operator and the
//          pipeline stage-count helper.
// Contents: kpg_t, KPG_KILL/KPG_PROP/KPG_GEN, kpg_combine(), stage_count().
package ppc_pkg;

  typedef logic [1:0] kpg_t;

  localparam kpg_t KPG_KILL = 2'b00;
  localparam kpg_t KPG_PROP = 2'b01;
  localparam kpg_t KPG_GEN  = 2'b11;

  // A propagating upper group takes the status of the lower group; otherwise
  // the upper group already decides its own carry.
  function automatic kpg_t kpg_combine(input kpg_t hi, input kpg_t lo);
    return (hi == KPG_PROP) ? lo : hi;
  endfunction

  function automatic int stage_count(input int log2w, input int lps);
    return (log2w + lps - 1) / lps;
  endfunction

endpackage

// File: rtl/ppc_level.sv
// rtl/ppc_level.sv - one combinational Kogge-Stone prefix level
// Purpose: combines each bit's KPG status with the status SPAN bits below it.
// Ports:
//   i_w  in   WIDTH x kpg_t   group status entering this level
//   o_w  out  WIDTH x kpg_t   group status after combining at distance SPAN
module ppc_level
  import ppc_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SPAN  = 1
) (
  input  kpg_t [WIDTH-1:0] i_w,
  output kpg_t [WIDTH-1:0] o_w
);

  for (genvar j = 0; j < WIDTH; j++) begin : g_bit
    if (j >= SPAN) begin : g_comb
      assign o_w[j] = kpg_combine(i_w[j], i_w[j-SPAN]);
    end else begin : g_pass
      assign o_w[j] = i_w[j];
    end
  end

endmodule

// File: rtl/ppc_pipe_adder.sv
// rtl/ppc_pipe_adder.sv - pipelined Kogge-Stone adder/subtractor with valid/ready
// Purpose: WIDTH-bit add/sub, one operation per cycle, latency NSTG+1 edges,
//          capacity NSTG+2 transactions, order preserved under backpressure.
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  operand handshake
//   a, b, cin, sub       operands; sub=1 computes a-b and ignores cin
//   out_valid/out_ready  result handshake
//   sum, cout, ovf       result, carry out (sub: 1 = no borrow), signed overflow
module ppc_pipe_adder
  import ppc_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int LPS   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int LOG2W = $clog2(WIDTH);
  localparam int NSTG  = stage_count(LOG2W, LPS);

  // Stage k in 0..NSTG carries p, the KPG vector and cin_eff; stage NSTG+1
  // is the result register.
  logic [NSTG+1:0]  r_v;
  logic [NSTG+1:0]  w_rdy;
  logic [WIDTH-1:0] r_p [0:NSTG];
  kpg_t [WIDTH-1:0] r_w [0:NSTG];
  logic [NSTG:0]    r_c;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic             w_cin;
  kpg_t [WIDTH-1:0] w_kpg0;
  kpg_t [WIDTH-1:0] w_lvl [1:NSTG];
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_sum;

  // A stage can load when it is empty or its content moves on this cycle;
  // the chain runs from the output back to stage 0 so bubbles collapse.
  always_comb begin
    w_rdy = '0;
    w_rdy[NSTG+1] = !r_v[NSTG+1] || out_ready;
    for (int k = NSTG; k >= 0; k--) begin
      w_rdy[k] = !r_v[k] || w_rdy[k+1];
    end
  end

  assign in_ready  = rst_n && w_rdy[0];
  assign out_valid = r_v[NSTG+1];
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

  // Encode: g and p are exclusive, so {g, p|g} yields only KILL/PROP/GEN.
  // Folding cin into bit 0 makes the prefix tree produce true carries.
  always_comb begin
    w_b    = sub ? ~b : b;
    w_cin  = sub | cin;
    w_p    = a ^ w_b;
    w_g    = a & w_b;
    w_kpg0 = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_kpg0[i] = {w_g[i], w_p[i] | w_g[i]};
    end
    if (w_kpg0[0] == KPG_PROP) begin
      w_kpg0[0] = w_cin ? KPG_GEN : KPG_KILL;
    end
  end

  // Each pipeline stage evaluates LPS levels; levels past LOG2W in the last
  // stage are plain wires.
  for (genvar s = 1; s <= NSTG; s++) begin : g_stg
    kpg_t [WIDTH-1:0] w_chain [0:LPS];
    assign w_chain[0] = r_w[s-1];
    for (genvar i = 0; i < LPS; i++) begin : g_lvl
      localparam int LVL = (s - 1) * LPS + i;
      if (LVL < LOG2W) begin : g_on
        ppc_level #(
          .WIDTH (WIDTH),
          .SPAN  (1 << LVL)
        ) u_level (
          .i_w (w_chain[i]),
          .o_w (w_chain[i+1])
        );
      end else begin : g_off
        assign w_chain[i+1] = w_chain[i];
      end
    end
    assign w_lvl[s] = w_chain[LPS];
  end

  // After the last level, a GEN at bit i means a carry into bit i+1.
  always_comb begin
    w_c    = '0;
    w_c[0] = r_c[NSTG];
    for (int i = 0; i < WIDTH; i++) begin
      w_c[i+1] = (r_w[NSTG][i] == KPG_GEN);
    end
    w_sum = r_p[NSTG] ^ w_c[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v    <= '0;
      r_c    <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      for (int k = 0; k <= NSTG; k++) begin
        r_p[k] <= '0;
        r_w[k] <= '0;
      end
    end else begin
      if (w_rdy[0]) begin
        r_v[0] <= in_valid;
      end
      for (int k = 1; k <= NSTG + 1; k++) begin
        if (w_rdy[k]) begin
          r_v[k] <= r_v[k-1];
        end
      end
      // Data only moves with a real transaction, keeping held results stable.
      if (w_rdy[0] && in_valid) begin
        r_p[0] <= w_p;
        r_w[0] <= w_kpg0;
        r_c[0] <= w_cin;
      end
      for (int k = 1; k <= NSTG; k++) begin
        if (w_rdy[k] && r_v[k-1]) begin
          r_p[k] <= r_p[k-1];
          r_w[k] <= w_lvl[k];
          r_c[k] <= r_c[k-1];
        end
      end
      if (w_rdy[NSTG+1] && r_v[NSTG]) begin
        r_sum  <= w_sum;
        r_cout <= w_c[WIDTH];
        r_ovf  <= w_c[WIDTH] ^ w_c[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_ppc_pipe_adder.sv
// tb/tb_ppc_pipe_adder.sv - scoreboard bench for ppc_pipe_adder (64/2 and 13/3 configs)
module tb_ppc_pipe_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst2_n;
  logic        v1, r1, ov1, or1, cin1, sub1, cout1, ovf1;
  logic [63:0] a1, b1, s1;
  logic        v2, r2, ov2, or2, cin2, sub2, cout2, ovf2;
  logic [12:0] a2, b2, s2;

  ppc_pipe_adder u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .a(a1), .b(b1),
    .cin(cin1), .sub(sub1), .out_valid(ov1), .out_ready(or1), .sum(s1),
    .cout(cout1), .ovf(ovf1)
  );

  ppc_pipe_adder #(.WIDTH(13), .LPS(3)) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .in_valid(v2), .in_ready(r2), .a(a2), .b(b2),
    .cin(cin2), .sub(sub2), .out_valid(ov2), .out_ready(or2), .sum(s2),
    .cout(cout2), .ovf(ovf2)
  );

  int n_run = 0;
  int n_fail = 0;
  int acc = 0;
  logic done2 = 1'b0;
  logic [65:0] q1[$];
  logic [65:0] q2[$];
  logic        hold1 = 1'b0;
  logic [65:0] held1;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send1(input logic [63:0] a, input logic [63:0] b, input logic c,
                       input logic s, input logic [65:0] exp);
    int t = 0;
    a1 = a; b1 = b; cin1 = c; sub1 = s; v1 = 1'b1;
    @(negedge clk);
    while (!r1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!r1) begin
      n_run++; n_fail++;
      $display("FAIL send1_timeout: in_ready stayed 0 for %0d cycles", t);
      v1 = 1'b0;
      return;
    end
    @(posedge clk);
    q1.push_back(exp);
    #1 v1 = 1'b0;
  endtask

  task automatic send2(input logic [12:0] a, input logic [12:0] b, input logic c,
                       input logic s, input logic [65:0] exp);
    int t = 0;
    a2 = a; b2 = b; cin2 = c; sub2 = s; v2 = 1'b1;
    @(negedge clk);
    while (!r2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!r2) begin
      n_run++; n_fail++;
      $display("FAIL send2_timeout: in_ready stayed 0 for %0d cycles", t);
      v2 = 1'b0;
      return;
    end
    @(posedge clk);
    q2.push_back(exp);
    #1 v2 = 1'b0;
  endtask

  function automatic logic [65:0] model13(input logic [12:0] a, input logic [12:0] b,
                                          input logic c, input logic s);
    logic [12:0] be;
    logic [13:0] f;
    logic        o;
    be = s ? ~b : b;
    f  = {1'b0, a} + {1'b0, be} + {13'b0, s | c};
    o  = (a[12] == be[12]) && (f[12] != a[12]);
    return {f[13], o, 51'b0, f[12:0]};
  endfunction

  // Monitors: pop and compare on each output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold1 = 1'b0;
    end else begin
      if (hold1 && ov1) check("hold1", {2'b0, cout1, ovf1, s1}, {2'b0, held1});
      hold1 = ov1 && !or1;
      held1 = {cout1, ovf1, s1};
      if (ov1 && or1) begin
        if (q1.size() == 0) begin
          n_run++; n_fail++;
          $display("FAIL unexpected1: got %h with no result pending", {cout1, ovf1, s1});
        end else begin
          check("res1", {2'b0, cout1, ovf1, s1}, {2'b0, q1.pop_front()});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst2_n && ov2 && or2) begin
      if (q2.size() == 0) begin
        n_run++; n_fail++;
        $display("FAIL unexpected2: got %h with no result pending", {cout2, ovf2, s2});
      end else begin
        check("res2", {2'b0, cout2, ovf2, 51'b0, s2}, {2'b0, q2.pop_front()});
      end
    end
  end

  always @(posedge clk) begin
    #1 or2 = ($urandom_range(0, 3) != 0);
  end

  // 13-bit / 3-levels-per-stage config: corners then random ops vs the model.
  initial begin
    logic [12:0] ra, rb;
    logic        rc, rs;
    v2 = 0; a2 = 0; b2 = 0; cin2 = 0; sub2 = 0; or2 = 1;
    rst2_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst2_n = 1'b1;
    @(posedge clk); #1;
    send2(13'h1FFF, 13'h0000, 1'b1, 1'b0, {1'b1, 1'b0, 51'b0, 13'h0000});
    send2(13'h0005, 13'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 51'b0, 13'h1FFE});
    send2(13'h0FFF, 13'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 51'b0, 13'h1000});
    send2(13'h1000, 13'h0001, 1'b1, 1'b1, {1'b1, 1'b1, 51'b0, 13'h0FFF});
    for (int n = 0; n < 400; n++) begin
      ra = 13'($urandom); rb = 13'($urandom);
      rc = 1'($urandom);  rs = 1'($urandom);
      send2(ra, rb, rc, rs, model13(ra, rb, rc, rs));
    end
    done2 = 1'b1;
  end

  initial begin
    rst_n = 1'b0; v1 = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0; or1 = 1;
    #1;
    check("reset_outputs", {ov1, r1, cout1, ovf1, s1}, '0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_release", r1, 1);

    // Carry ripples through all 64 bits; result 4 edges after accept.
    send1(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, {1'b1, 1'b0, 64'h0});
    repeat (3) @(posedge clk);
    #1 check("latency_not_early", ov1, 0);
    @(posedge clk);
    #1 check("latency_4", ov1, 1);

    send1(64'd5, 64'd7, 1'b0, 1'b1, {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
    send1(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, {1'b0, 1'b1, 64'h8000_0000_0000_0000});
    send1(64'd5, 64'd7, 1'b1, 1'b1, {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
    send1(64'd7, 64'd5, 1'b0, 1'b1, {1'b1, 1'b0, 64'd2});
    send1(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, {1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF});
    send1(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, {1'b1, 1'b1, 64'h0});
    send1(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1, 1'b0,
          {1'b0, 1'b0, 64'h1234_5678_9ABC_DF01});
    repeat (6) @(posedge clk); #1;

    // Backpressure: capacity 5, then 8 results back-to-back in order.
    or1 = 1'b0;
    acc = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send1(64'h1000 + 64'(i), 64'(i), 1'b0, 1'b0, {2'b00, 64'h1000 + 64'(2 * i)});
          acc++;
        end
      end
      begin
        repeat (12) @(posedge clk);
        #2;
        check("bp_accepted", acc, 5);
        check("bp_in_ready_low", r1, 0);
        check("bp_out_valid_held", ov1, 1);
        @(posedge clk);
        #1 or1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          check("bp_one_per_cycle", ov1, 1);
        end
      end
    join
    repeat (6) @(posedge clk); #1;

    // Reset with 3 in flight: everything discarded.
    send1(64'd1, 64'd2, 1'b0, 1'b0, {2'b00, 64'd3});
    send1(64'd3, 64'd4, 1'b0, 1'b0, {2'b00, 64'd7});
    send1(64'd5, 64'd6, 1'b0, 1'b0, {2'b00, 64'd11});
    #1 rst_n = 1'b0;
    q1.delete();
    #1;
    check("midrst_out_valid", ov1, 0);
    check("midrst_sum", {cout1, ovf1, s1}, 0);
    check("midrst_in_ready", r1, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("midrst_ready_release", r1, 1);
    send1(64'd9, 64'd10, 1'b1, 1'b0, {2'b00, 64'd20});
    repeat (3) @(posedge clk);
    #1 check("midrst_no_stale", ov1, 0);
    @(posedge clk);
    #1 check("midrst_latency_4", ov1, 1);

    for (int t = 0; t < 3000 && !(done2 && q1.size() == 0 && q2.size() == 0); t++) begin
      @(posedge clk);
    end
    repeat (2) @(negedge clk);
    check("drain1_pending", q1.size(), 0);
    check("drain2_pending", q2.size(), 0);
    check("dut2_stimulus_done", done2, 1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
